share_add_seq: RTL and testbench

// - Sequential sibling of the shared select-add datapath: one physical adder, reused over two cycles.
// - Computes z = k + s + s, where s = x ? w : v, i.e. the "y = k+s; z = y+s" chain.
// - Operands enter through a valid/ready input handshake; the result leaves through a valid/ready output handshake.
// - Sits between the operand source and the result consumer; trades latency for a single adder.

---
 rtl/share_add_seq.sv | 196 +++++++++++++++++++
 tb/tb_share_add_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/share_add_seq.sv
// -----------------------------------------------------------------------------
// share_add_seq
//
// Purpose:
//   Sequential select-add datapath built around one physical adder that is
//   used twice. It computes z = k + s + s, where s = x ? w : v, as the chain
//   y = k + s (first pass), z = y + s (second pass). Operands arrive through a
//   valid/ready handshake and the result leaves through a second valid/ready
//   handshake. One result takes four cycles: IDLE, ADD1, ADD2, HOLD.
//
// Configuration:
//   SHARE_ADD_SAT_EN  When defined, results above 2^(WIDTH+1)-1 are clamped to
//                     that value and sat is raised alongside out_valid. When
//                     undefined, z carries the full WIDTH+2 bit sum and sat is
//                     tied to 0.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand set present on k/v/w/x
//   in_ready   out  1        block can accept an operand set (IDLE only)
//   k          in   WIDTH    base operand
//   v          in   WIDTH    operand used when x=0
//   w          in   WIDTH    operand used when x=1
//   x          in   1        operand select
//   out_valid  out  1        z valid (HOLD only)
//   out_ready  in   1        consumer accepts z
//   z          out  WIDTH+2  result; keeps its last value after handoff
//   sat        out  1        result was clamped (SHARE_ADD_SAT_EN builds only)
//   op_cnt     out  CNT_W    number of results handed off, wraps silently
// -----------------------------------------------------------------------------
module share_add_seq #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   k,
  input  logic [WIDTH-1:0]   v,
  input  logic [WIDTH-1:0]   w,
  input  logic               x,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   z,
  output logic               sat,
  output logic [CNT_W-1:0]   op_cnt
);

  localparam int SW = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD1 = 2'd1,
    ADD2 = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Datapath registers
  logic [SW-1:0]    k_q;
  logic [SW-1:0]    s_q;
  logic [SW-1:0]    acc_q;
  logic [SW-1:0]    z_q;
  logic [CNT_W-1:0] op_cnt_q;

  // Control strobes from the output process
  logic load_ops;
  logic load_acc;
  logic load_z;
  logic cnt_inc;

  // Shared adder signals
  logic [SW-1:0] add_a;
  logic [SW-1:0] sum;
  logic [SW-1:0] sel_ext;
  logic [SW-1:0] z_load_val;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = ADD1;
      ADD1:                   state_d = ADD2;
      ADD2:                   state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath strobes, all decoded from the current state.
  // in_ready depends on state only, so an in_valid seen in HOLD is not taken
  // until the following IDLE cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load_ops  = 1'b0;
    load_acc  = 1'b0;
    load_z    = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        load_ops = in_valid;
      end
      ADD1: load_acc = 1'b1;
      ADD2: load_z   = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        cnt_inc   = out_ready;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand select, zero-extended to the sum width at capture time
  // ---------------------------------------------------------------------------
  assign sel_ext = x ? {2'b00, w} : {2'b00, v};

  // The one adder: its left operand is k during ADD1 and the partial sum
  // during ADD2; the right operand is always the captured select value.
  assign add_a = (state_q == ADD2) ? acc_q : k_q;
  assign sum   = add_a + s_q;

`ifdef SHARE_ADD_SAT_EN
  localparam logic [SW-1:0] ZMAX = {1'b0, {(WIDTH+1){1'b1}}};

  logic over;
  logic sat_q;

  assign over       = (sum > ZMAX);
  assign z_load_val = over ? ZMAX : sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (load_z) begin
      sat_q <= over;
    end
  end

  assign sat = sat_q;
`else
  assign z_load_val = sum;
  assign sat        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      s_q      <= '0;
      acc_q    <= '0;
      z_q      <= '0;
      op_cnt_q <= '0;
    end else begin
      if (load_ops) begin
        k_q <= {2'b00, k};
        s_q <= sel_ext;
      end
      if (load_acc) begin
        acc_q <= sum;
      end
      if (load_z) begin
        z_q <= z_load_val;
      end
      if (cnt_inc) begin
        op_cnt_q <= op_cnt_q + 1'b1;
      end
    end
  end

  assign z      = z_q;
  assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_share_add_seq.sv
module tb_share_add_seq;

  localparam int WIDTH = 3;
  localparam int CNT_W = 8;
  localparam int ZMAX  = (1 << (WIDTH + 1)) - 1;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   k;
  logic [WIDTH-1:0]   v;
  logic [WIDTH-1:0]   w;
  logic               x;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH+1:0]   z;
  logic               sat;
  logic [CNT_W-1:0]   op_cnt;

  int n_assert;
  int n_fail;
  int exp_cnt;   // reference count of completed handoffs, unbounded

  share_add_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .k         (k),
    .v         (v),
    .w         (w),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .sat       (sat),
    .op_cnt    (op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: z = k + 2*s in plain integers, then optional clamp.
  function automatic int ref_z(input int kk, input int vv, input int ww, input bit xx);
    int s;
    int r;
    s = xx ? ww : vv;
    r = kk + 2 * s;
`ifdef SHARE_ADD_SAT_EN
    if (r > ZMAX) r = ZMAX;
`endif
    return r;
  endfunction

  function automatic int ref_sat(input int kk, input int vv, input int ww, input bit xx);
`ifdef SHARE_ADD_SAT_EN
    int s;
    s = xx ? ww : vv;
    return (kk + 2 * s > ZMAX) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  // One full transaction: accept, two adder passes, optional stall in HOLD
  // with in_valid held high, then handoff.
  task automatic do_op(input int kk, input int vv, input int ww, input bit xx,
                       input int stall, input bit chg);
    int ez;
    int es;
    ez = ref_z(kk, vv, ww, xx);
    es = ref_sat(kk, vv, ww, xx);
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    k = kk[WIDTH-1:0]; v = vv[WIDTH-1:0]; w = ww[WIDTH-1:0]; x = xx;
    in_valid = 1'b1;
    @(posedge clk); #1;                       // E0: accept
    in_valid = 1'b0;
    if (chg) begin k = '0; v = '0; w = '0; x = ~xx; end
    @(negedge clk);                           // in ADD1
    chk("add1_out_valid", out_valid, 0);
    chk("add1_in_ready", in_ready, 0);
    @(negedge clk);                           // in ADD2
    chk("add2_out_valid", out_valid, 0);
    @(negedge clk);                           // in HOLD after E2
    chk("hold_out_valid", out_valid, 1);
    chk("hold_z", z, ez);
    chk("hold_sat", sat, es);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      k = WIDTH'($urandom); v = WIDTH'($urandom); w = WIDTH'($urandom); x = 1'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_z", z, ez);
      chk("stall_sat", sat, es);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;                       // output handshake
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_cnt++;
    @(negedge clk);
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_op_cnt", op_cnt, exp_cnt % (1 << CNT_W));
    chk("post_z_kept", z, ez);
    $display("op k=%0d v=%0d w=%0d x=%0d stall=%0d -> z=%0d sat=%0d cnt=%0d",
             kk, vv, ww, xx, stall, z, sat, op_cnt);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; exp_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k = '0; v = '0; w = '0; x = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_z", z, 0);
    chk("rst_sat", sat, 0);
    chk("rst_op_cnt", op_cnt, 0);

    // Directed cases
    do_op(5, 0, 6, 1'b1, 0, 1'b0);   // 17, or clamp 15
    do_op(5, 2, 0, 1'b0, 0, 1'b1);   // 9, operands zeroed during ADD1
    do_op(7, 7, 7, 1'b1, 0, 1'b0);   // 21, or clamp 15
    do_op(3, 1, 6, 1'b0, 4, 1'b0);   // 5, four-cycle stall with in_valid high
    do_op(0, 0, 0, 1'b0, 0, 1'b0);   // 0

    // Random cases; enough of them to wrap op_cnt
    for (int n = 0; n < 260; n++) begin
      do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 2)),
            1'($urandom));
    end

    // Reset pulse during ADD2 abandons the operation
    @(negedge clk);
    k = 3'd6; v = 3'd6; w = 3'd6; x = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);                           // ADD1
    @(negedge clk);                           // ADD2
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_z", z, 0);
    chk("midrst_op_cnt", op_cnt, 0);
    chk("midrst_sat", sat, 0);
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", out_valid, 0);
      chk("midrst_idle", in_ready, 1);
    end
    do_op(1, 1, 0, 1'b0, 0, 1'b0);            // 3

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
